collision_map_arbiter: RTL and testbench
========================================

Name: collision_map_arbiter

Overview:
- Round-robin arbiter that shares the single read port of the collision-map ROM (4-bit pixel per address) between several game-object controllers, e.g. player Y control, player X control and projectile control.
- Each requester presents a pixel address. The arbiter grants one requester per cycle, drives the ROM and routes the returned pixel back to the correct requester with a valid strobe.
- Sits between the game controllers and the collision-map ROM in the game clock domain.

Parameters:
N_REQ, 3, number of requesters (2..8)
ADDR_W, 16, ROM address width ({y[6:0], x[8:0]} packing)
DATA_W, 4, ROM pixel width
RD_LAT, 2, ROM read latency in cycles from rom_en to rom_data valid (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  N_REQ  per-requester read request, level
req_addr  in  N_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W]
gnt  out  N_REQ  one-hot grant pulse, registered
rsp_valid  out  N_REQ  one-hot response strobe, registered
rsp_data  out  DATA_W  pixel for the requester flagged in rsp_valid, registered
rom_addr  out  ADDR_W  ROM address, registered
rom_en  out  1  ROM read enable, registered
rom_data  in  DATA_W  ROM read data, valid RD_LAT cycles after rom_en

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, rom_addr=0, rom_en=0, pending=0, rr_ptr=0, tag pipeline cleared.
- pending[i]: set on the cycle gnt[i] is driven; cleared on the cycle rsp_valid[i] is driven.
- Eligible set: elig = req & ~pending. A requester has at most one read outstanding.
- Arbitration (combinational on elig):
  - Search indices rr_ptr, rr_ptr+1, … mod N_REQ; the first eligible index wins.
  - Next cycle: gnt[win]=1, rom_en=1, rom_addr=req_addr[win], rr_ptr=(win+1) mod N_REQ.
  - If no index is eligible: gnt=0, rom_en=0, rom_addr holds its value, rr_ptr holds.
- Timeline (cycle numbers): req sampled high in cycle 0 → gnt/rom_en/rom_addr in cycle 1 → rom_data valid in cycle 1+RD_LAT → rsp_valid[i]=1 and rsp_data=rom_data registered in cycle 2+RD_LAT. Total latency is RD_LAT+2 cycles.
- Tag pipeline: shift register of depth RD_LAT carrying {valid, id[$clog2(N_REQ)-1:0]}, loaded with the grant. Its output selects which rsp_valid bit fires. Throughput is one grant and one response per cycle.
- Requester protocol:
  - req_addr must be stable while req=1 and gnt[i]=0. The address is captured at grant.
  - The requester may hold req high continuously. A new read becomes eligible the cycle after rsp_valid[i].
  - req dropped before grant means no grant and no response, with no error.
- Simultaneous events:
  - The grant to i and the rsp_valid to j≠i in the same cycle are independent.
  - rsp_valid[i] in the same cycle as req[i] still high: pending[i] is 0 from the next cycle, so the earliest re-grant is the cycle after that.
- rsp_data holds its last value when rsp_valid=0.
- Reset mid-operation: pending, rr_ptr and the tag pipeline clear. ROM data already in flight is discarded and no rsp_valid fires for it.
- Fairness: with all requesters continuously requesting, each is granted at least once every N_REQ grants. With single outstanding reads and RD_LAT=2, every requester is served within N_REQ+RD_LAT+2 cycles.

Test Plan:
- RD_LAT=2, only req[0]=1 at cycle 0, addr 0x0A05 → gnt[0] and rom_addr=0x0A05 at cycle 1; ROM returns 0x3 at cycle 3; rsp_valid[0]=1 with rsp_data=0x3 at cycle 4; no other outputs active.
- All 3 requesting from cycle 0 with addrs 0x0100/0x0200/0x0300 → gnt order 0,1,2 at cycles 1,2,3; rsp_valid 0,1,2 at cycles 4,5,6 with the matching ROM data; each id's data is correct.
- All 3 holding req continuously for 30 cycles → grant counts per requester differ by ≤1; no requester is granted twice while pending.
- rr_ptr=2, then req[0] and req[2] rise together → req[2] is granted first, req[0] next cycle; rr_ptr ends at 1.
- rst for one cycle at cycle 2 after grants at cycles 1 and 2 → no rsp_valid ever fires for those grants; the next request is granted starting with index 0.
- RD_LAT=1 build, single request at cycle 0 → rsp_valid at cycle 3. RD_LAT=4 build → rsp_valid at cycle 6.

Source files
------------

// File: rtl/collision_map_arbiter_if.sv
// Bundle between the game-object controllers, the collision-map arbiter and the ROM read port.
// Handshake: req[i] is a level that stays high with req_addr slice i stable until gnt[i] pulses;
// rsp_valid[i] is a one-cycle strobe carrying rsp_data; rom_data is valid RD_LAT cycles after rom_en.
interface collision_map_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 4
);
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]       rsp_data;
   logic [ADDR_W-1:0]       rom_addr;
   logic                    rom_en;
   logic [DATA_W-1:0]       rom_data;

   modport master (
      output req, req_addr, rom_data,
      input  gnt, rsp_valid, rsp_data, rom_addr, rom_en
   );

   modport slave (
      input  req, req_addr, rom_data,
      output gnt, rsp_valid, rsp_data, rom_addr, rom_en
   );
endinterface

// File: rtl/collision_map_arbiter.sv
// Round-robin arbiter sharing the collision-map ROM read port between game-object controllers.
// A tag pipeline tracks which requester owns each in-flight read so the pixel is routed back.
module collision_map_arbiter #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 4,
   parameter int RD_LAT = 2
) (
   input logic                    clk,
   input logic                    rst,
   collision_map_arbiter_if.slave bus
);
   localparam int IDW = $clog2(N_REQ);

   logic [N_REQ-1:0]  pending;
   logic [N_REQ-1:0]  elig;
   logic [N_REQ-1:0]  win_oh;
   logic [IDW-1:0]    rr_ptr;
   logic [IDW-1:0]    win;
   logic [IDW-1:0]    cand;
   logic [IDW-1:0]    next_ptr;
   logic              found;
   logic [ADDR_W-1:0] sel_addr;

   logic [N_REQ-1:0]  gnt_r;
   logic [IDW-1:0]    gnt_id;
   logic              rom_en_r;
   logic [ADDR_W-1:0] rom_addr_r;
   logic [N_REQ-1:0]  rsp_valid_r;
   logic [DATA_W-1:0] rsp_data_r;

   logic [RD_LAT-1:0] tag_v;
   logic [IDW-1:0]    tag_id [RD_LAT];

   assign elig = bus.req & ~pending;

   // First eligible index at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % N_REQ);
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      win_oh   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win == IDW'(k)) begin
            sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
            win_oh[k] = found;
         end
      end
   end

   assign next_ptr = (win == IDW'(N_REQ - 1)) ? '0 : win + IDW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_r       <= '0;
         gnt_id      <= '0;
         rom_en_r    <= 1'b0;
         rom_addr_r  <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
         rr_ptr      <= '0;
         pending     <= '0;
         tag_v       <= '0;
         for (int j = 0; j < RD_LAT; j++) tag_id[j] <= '0;
      end else begin
         gnt_r    <= win_oh;
         rom_en_r <= found;
         if (found) begin
            rom_addr_r <= sel_addr;
            rr_ptr     <= next_ptr;
            gnt_id     <= win;
         end

         // Stage RD_LAT-1 lines up with rom_data for the read issued RD_LAT cycles earlier.
         tag_v[0]  <= rom_en_r;
         tag_id[0] <= gnt_id;
         for (int j = 1; j < RD_LAT; j++) begin
            tag_v[j]  <= tag_v[j-1];
            tag_id[j] <= tag_id[j-1];
         end

         rsp_valid_r <= '0;
         if (tag_v[RD_LAT-1]) begin
            rsp_valid_r[tag_id[RD_LAT-1]] <= 1'b1;
            rsp_data_r                    <= bus.rom_data;
         end

         // Clearing on the registered strobe makes a requester eligible the cycle after rsp_valid.
         pending <= (pending & ~rsp_valid_r) | win_oh;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.rom_en    = rom_en_r;
   assign bus.rom_addr  = rom_addr_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
endmodule

// File: tb/tb_collision_map_arbiter.sv
// Bench for collision_map_arbiter: randomized and directed requests checked against a
// cycle-level round-robin model with an expected-response queue; extra builds check RD_LAT 1 and 4.
module tb_collision_map_arbiter;
   localparam int N   = 3;
   localparam int AW  = 16;
   localparam int DW  = 4;
   localparam int LAT = 2;
   localparam int QW  = 44;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   collision_map_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus  ();
   collision_map_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();
   collision_map_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus4 ();

   collision_map_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   collision_map_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_l1 (
      .clk(clk), .rst(rst), .bus(bus1));
   collision_map_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(4)) dut_l4 (
      .clk(clk), .rst(rst), .bus(bus4));

   // ROM contents and per-build read pipelines; garbage is presented when no read is due.
   logic [DW-1:0] rom_mem [0:65535];
   logic [DW-1:0] p2 [0:1];
   logic [DW-1:0] p1 [0:0];
   logic [DW-1:0] p4 [0:3];

   always @(posedge clk) begin
      p2[0] <= bus.rom_en ? rom_mem[bus.rom_addr] : 4'($urandom);
      p2[1] <= p2[0];
      p1[0] <= bus1.rom_en ? rom_mem[bus1.rom_addr] : 4'($urandom);
      p4[0] <= bus4.rom_en ? rom_mem[bus4.rom_addr] : 4'($urandom);
      p4[1] <= p4[0];
      p4[2] <= p4[1];
      p4[3] <= p4[2];
   end
   assign bus.rom_data  = p2[1];
   assign bus1.rom_data = p1[0];
   assign bus4.rom_data = p4[3];

   logic [N-1:0]  drv_req;
   logic [AW-1:0] drv_addr [N];
   logic [N-1:0]  lreq;

   always_comb begin
      bus.req_addr = '0;
      for (int k = 0; k < N; k++) bus.req_addr[k*AW +: AW] = drv_addr[k];
   end
   assign bus.req   = drv_req;
   assign bus1.req  = lreq;
   assign bus4.req  = lreq;
   assign bus1.req_addr = {16'h0000, 16'h0000, 16'h0A05};
   assign bus4.req_addr = {16'h0000, 16'h0000, 16'h0A05};

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model state
   logic          mon_on  = 1'b0;
   logic          rand_on = 1'b0;
   logic          cnt_on  = 1'b0;
   int            cyc     = 0;
   int            m_rr;
   int            busy_until [N];
   int            gcnt [N];
   logic [N-1:0]  exp_gnt;
   logic          exp_en;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] last_data;
   logic [QW-1:0] exp_q [$];

   initial begin
      logic [QW-1:0] e;
      logic [N-1:0]  oh;
      int            idx;
      int            win;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            check("gnt", 64'(bus.gnt), 64'(exp_gnt));
            check("rom_en", 64'(bus.rom_en), 64'(exp_en));
            check("rom_addr", 64'(bus.rom_addr), 64'(exp_addr));
            if (cnt_on)
               for (int i = 0; i < N; i++) if (bus.gnt[i]) gcnt[i]++;
            if (bus.rsp_valid == '0) begin
               check("rsp_data_hold", 64'(bus.rsp_data), 64'(last_data));
               if (exp_q.size() > 0 && int'(exp_q[0][43:12]) <= cyc) begin
                  e = exp_q.pop_front();
                  check("rsp_missing", 64'(0), 64'(e[11:4]) + 64'd1);
               end
            end else if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
            end else begin
               e  = exp_q.pop_front();
               oh = '0;
               oh[e[11:4]] = 1'b1;
               check("rsp_cycle", 64'(cyc), 64'(e[43:12]));
               check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
               check("rsp_data", 64'(bus.rsp_data), 64'(e[3:0]));
               last_data = e[3:0];
            end
         end
         if (rst) begin
            exp_gnt   = '0;
            exp_en    = 1'b0;
            exp_addr  = '0;
            last_data = '0;
            m_rr      = 0;
            for (int i = 0; i < N; i++) busy_until[i] = -1;
            exp_q.delete();
         end else begin
            win = -1;
            for (int k = 0; k < N; k++) begin
               idx = (m_rr + k) % N;
               if (win < 0 && drv_req[idx] && cyc > busy_until[idx]) win = idx;
            end
            exp_gnt = '0;
            exp_en  = (win >= 0);
            if (win >= 0) begin
               exp_gnt[win]    = 1'b1;
               exp_addr        = drv_addr[win];
               m_rr            = (win + 1) % N;
               busy_until[win] = cyc + 2 + LAT;
               exp_q.push_back({32'(cyc + 2 + LAT), 8'(win), rom_mem[drv_addr[win]]});
            end
         end
         cyc++;
      end
   end

   // Random requesters: only change address when idle or just granted; sometimes withdraw.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_on) begin
            for (int i = 0; i < N; i++) begin
               if (!drv_req[i] || bus.gnt[i]) begin
                  drv_req[i]  = 1'($urandom_range(0, 1));
                  drv_addr[i] = 16'($urandom);
               end else if ($urandom_range(0, 7) == 0) begin
                  drv_req[i] = 1'b0;
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      int gmax, gmin, l1, l4;
      logic [DW-1:0] d1, d4;
      logic [N-1:0]  v1, v4;
      for (int a = 0; a < 65536; a++) rom_mem[a] = 4'($urandom);
      rom_mem[16'h0A05] = 4'h3;
      drv_req = '0;
      lreq    = '0;
      for (int i = 0; i < N; i++) begin
         drv_addr[i] = '0;
         gcnt[i]     = 0;
      end
      rst = 1'b1;
      step(3);
      rst    = 1'b0;
      mon_on = 1'b1;
      check("reset_gnt", 64'(bus.gnt), 64'(0));
      check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("reset_rsp_data", 64'(bus.rsp_data), 64'(0));
      check("reset_rom_addr", 64'(bus.rom_addr), 64'(0));
      check("reset_rom_en", 64'(bus.rom_en), 64'(0));

      // Single request from requester 0
      drv_addr[0] = 16'h0A05;
      drv_req     = 3'b001;
      step(1);
      drv_req = '0;
      step(8);

      // All three requesting together
      drv_addr[0] = 16'h0100;
      drv_addr[1] = 16'h0200;
      drv_addr[2] = 16'h0300;
      drv_req     = 3'b111;
      step(3);
      drv_req = '0;
      step(10);

      // Move the pointer to 2, then 0 and 2 together
      drv_req = 3'b010;
      step(1);
      drv_req = '0;
      step(6);
      drv_req = 3'b101;
      step(2);
      drv_req = '0;
      step(8);

      // Continuous requests from everyone
      for (int i = 0; i < N; i++) drv_addr[i] = 16'($urandom);
      drv_req = 3'b111;
      cnt_on  = 1'b1;
      step(30);
      cnt_on  = 1'b0;
      drv_req = '0;
      gmax = gcnt[0];
      gmin = gcnt[0];
      for (int i = 1; i < N; i++) begin
         if (gcnt[i] > gmax) gmax = gcnt[i];
         if (gcnt[i] < gmin) gmin = gcnt[i];
      end
      check("fair_spread_ok", 64'(gmax - gmin <= 1), 64'(1));
      check("fair_granted_ok", 64'(gmin >= 5), 64'(1));
      step(10);

      // Reset with two reads in flight
      drv_req = 3'b111;
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(6);
      drv_req = '0;
      step(10);

      // Randomized traffic
      rand_on = 1'b1;
      step(600);
      rand_on = 1'b0;
      step(1);
      drv_req = '0;
      step(12);

      // Latency of the RD_LAT=1 and RD_LAT=4 builds
      l1 = -1;
      l4 = -1;
      d1 = '0;
      d4 = '0;
      v1 = '0;
      v4 = '0;
      lreq = 3'b001;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) lreq = '0;
         if (bus1.rsp_valid != '0 && l1 < 0) begin
            l1 = n;
            d1 = bus1.rsp_data;
            v1 = bus1.rsp_valid;
         end
         if (bus4.rsp_valid != '0 && l4 < 0) begin
            l4 = n;
            d4 = bus4.rsp_data;
            v4 = bus4.rsp_valid;
         end
      end
      check("lat1_cycles", 64'(l1), 64'(3));
      check("lat1_valid", 64'(v1), 64'(1));
      check("lat1_data", 64'(d1), 64'(3));
      check("lat4_cycles", 64'(l4), 64'(6));
      check("lat4_valid", 64'(v4), 64'(1));
      check("lat4_data", 64'(d4), 64'(3));

      mon_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
